// File: rtl/pwm_pkg.sv
// Shared definitions for the multi-channel complementary PWM block.
// Holds the control FSM state encoding and the default counter width,
// dead time and blanking window length used by pwm_nch and pwm_chan.
package pwm_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StDrain = 2'd2
  } pwm_state_e;

  localparam int unsigned PwmW     = 11;
  localparam int unsigned PwmDt    = 64;
  localparam int unsigned PwmBlank = 128;

endpackage

// File: rtl/pwm_chan.sv
// One complementary PWM channel: compares the shared period counter against
// this channel's active duty to produce registered high/low-side drives with
// dead time, plus a combinational over-current blanking window after each
// switching edge.
//
// Ports:
//   clk, rst_n  clock / asynchronous active-low reset
//   act         period counter is live (RUN or DRAIN)
//   cnt         shared period counter
//   duty        active duty value for this channel
//   hi, lo      registered high-side / low-side drive
//   blank       combinational blanking flag
module pwm_chan
  import pwm_pkg::*;
#(
  parameter int unsigned W     = PwmW,
  parameter int unsigned DT    = PwmDt,
  parameter int unsigned BLANK = PwmBlank
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         act,
  input  logic [W-1:0] cnt,
  input  logic [W-1:0] duty,
  output logic         hi,
  output logic         lo,
  output logic         blank
);

  // One extra bit so duty+DT and duty+DT+BLANK cannot wrap back into range.
  localparam logic [W:0] DtX    = (W+1)'(DT);
  localparam logic [W:0] BlankX = (W+1)'(BLANK);
  localparam logic [W:0] LastX  = {1'b0, {W{1'b1}}};

  logic [W:0] cnt_x;
  logic [W:0] duty_x;
  logic [W:0] lo_start;
  logic       hi_d, hi_q;
  logic       lo_d, lo_q;

  assign cnt_x    = {1'b0, cnt};
  assign duty_x   = {1'b0, duty};
  assign lo_start = duty_x + DtX;

  // hi ends at duty and lo starts DT later, so the two windows are disjoint.
  always_comb begin
    hi_d  = act && (cnt_x >= DtX) && (cnt_x < duty_x);
    lo_d  = act && (cnt_x >= lo_start) && (cnt_x < LastX);
    blank = act && (((cnt_x > DtX) && (cnt_x < DtX + BlankX)) ||
                    ((cnt_x > lo_start) && (cnt_x < lo_start + BlankX)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q <= 1'b0;
      lo_q <= 1'b0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: rtl/pwm_nch.sv
// Multi-channel complementary PWM generator with dead time and blanking.
// A shared W-bit period counter runs while the control FSM is in RUN or
// DRAIN. Duty sets arrive through a one-deep pending buffer (valid/ready)
// and are promoted to the active duties only at a period boundary, so a
// pulse is never reshaped mid-period. Dropping en lets the current period
// finish (DRAIN) before returning to IDLE.
//
// Ports:
//   clk, rst_n  clock / asynchronous active-low reset
//   en          run request
//   duty_in     NCH packed duty values, channel c at [c*W +: W]
//   duty_vld    duty_in valid
//   duty_rdy    pending buffer is empty and can accept a duty set
//   hi, lo      per-channel high-side / low-side drive
//   blank       per-channel over-current blanking
//   synch       period-start pulse
//   running     FSM is in RUN or DRAIN
module pwm_nch
  import pwm_pkg::*;
#(
  parameter int unsigned W     = PwmW,
  parameter int unsigned NCH   = 2,
  parameter int unsigned DT    = PwmDt,
  parameter int unsigned BLANK = PwmBlank
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [NCH*W-1:0] duty_in,
  input  logic             duty_vld,
  output logic             duty_rdy,
  output logic [NCH-1:0]   hi,
  output logic [NCH-1:0]   lo,
  output logic [NCH-1:0]   blank,
  output logic             synch,
  output logic             running
);

  pwm_state_e       state_q, state_d;
  logic [W-1:0]     cnt_q, cnt_d;
  logic [NCH*W-1:0] pend_q, pend_d;
  logic [NCH*W-1:0] duty_q, duty_d;
  logic             full_q, full_d;
  logic             act;
  logic             cnt_last;
  logic             capture;
  logic             load;

  assign act      = (state_q != StIdle);
  assign cnt_last = &cnt_q;
  assign capture  = duty_vld && !full_q;
  // Promote only at a period boundary; capture needs the buffer empty and
  // load needs it full, so the two never coincide.
  assign load     = full_q && (((state_q == StIdle) && en) ||
                               ((state_q == StRun) && cnt_last));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (en) state_d = StRun;
      StRun:   if (!en) state_d = StDrain;
      StDrain: begin
        if (en) begin
          state_d = StRun;
        end else if (cnt_last) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    // DRAIN->IDLE happens at the last count, so the increment lands on 0.
    cnt_d  = act ? cnt_q + W'(1) : '0;
    pend_d = pend_q;
    full_d = full_q;
    duty_d = duty_q;
    if (capture) begin
      pend_d = duty_in;
      full_d = 1'b1;
    end
    if (load) begin
      duty_d = pend_q;
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      pend_q  <= '0;
      full_q  <= 1'b0;
      duty_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      full_q  <= full_d;
      duty_q  <= duty_d;
    end
  end

  assign duty_rdy = !full_q;
  assign synch    = act && (cnt_q == '0);
  assign running  = act;

  for (genvar c = 0; c < NCH; c++) begin : g_chan
    pwm_chan #(
      .W     (W),
      .DT    (DT),
      .BLANK (BLANK)
    ) u_chan (
      .clk   (clk),
      .rst_n (rst_n),
      .act   (act),
      .cnt   (cnt_q),
      .duty  (duty_q[c*W +: W]),
      .hi    (hi[c]),
      .lo    (lo[c]),
      .blank (blank[c])
    );
  end

endmodule

// File: doc/pwm_nch.md
PWM_NCH -- requirements
Module: pwm_nch

Interface
REQ-001 Parameter W, default 11, counter and duty width in bits.
REQ-002 Parameter NCH, default 2, number of complementary output channel pairs.
REQ-003 Parameter DT, default 64, non-overlap dead time in clocks; legal range 0 to 2^W-1.
REQ-004 Parameter BLANK, default 128, over-current blanking window length in clocks.
REQ-005 The module SHALL have a port clk, input, 1 bit: system clock; all logic on its rising edge.
REQ-006 The module SHALL have a port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-007 The module SHALL have a port en, input, 1 bit: run request.
REQ-008 The module SHALL have a port duty_in, input, NCH*W bits: unsigned duty values; channel c is bits [c*W +: W].
REQ-009 The module SHALL have a port duty_vld, input, 1 bit: duty_in is valid.
REQ-010 The module SHALL have a port duty_rdy, output, 1 bit: the pending buffer can accept a duty set.
REQ-011 The module SHALL have a port hi, output, NCH bits: high-side PWM, one bit per channel.
REQ-012 The module SHALL have a port lo, output, NCH bits: low-side PWM, one bit per channel.
REQ-013 The module SHALL have a port blank, output, NCH bits: over-current blanking, one bit per channel.
REQ-014 The module SHALL have a port synch, output, 1 bit: period-start pulse.
REQ-015 The module SHALL have a port running, output, 1 bit: high when the state is RUN or DRAIN.

Function
REQ-016 The control FSM SHALL have three states: IDLE, RUN and DRAIN.
- IDLE -> RUN when en=1.
- RUN -> DRAIN when en=0.
- DRAIN -> RUN when en=1 before the wrap.
- DRAIN -> IDLE when cnt=2^W-1.
REQ-017 Counter cnt (W bits) SHALL increment each cycle in RUN and DRAIN, wrap from 2^W-1 to 0, and be held at 0 in IDLE.
REQ-018 Pending duty buffer handshake:
- duty_in SHALL be captured when duty_vld and duty_rdy are both 1.
- The buffer SHALL then be marked full.
- duty_rdy SHALL equal NOT full.
REQ-019 Active duty update:
- Active duties SHALL load from a full pending buffer only on the IDLE->RUN transition or when cnt=2^W-1 in RUN.
- The buffer SHALL be marked empty in the same cycle.
- Active duties SHALL never change mid-period.
REQ-020 All channel comparisons SHALL use W+1-bit unsigned arithmetic so that duty+DT and duty+DT+BLANK never wrap.
REQ-021 hi[c] SHALL be registered, with its next value set when DT <= cnt < duty[c] and cleared otherwise; duty[c] <= DT therefore never asserts hi[c].
REQ-022 lo[c] SHALL be registered, with its next value set when duty[c]+DT <= cnt < 2^W-1 and cleared otherwise; duty[c]+DT >= 2^W-1 therefore never asserts lo[c].
REQ-023 hi[c] and lo[c] SHALL never be high in the same cycle, and each SHALL follow its comparison on cnt with 1-cycle latency.
REQ-024 blank[c] SHALL be combinational and high in RUN or DRAIN when DT < cnt < DT+BLANK, or when duty[c]+DT < cnt < duty[c]+DT+BLANK.
REQ-025 synch SHALL be combinational and equal 1 exactly when the state is RUN or DRAIN and cnt=0.
REQ-026 In IDLE, hi, lo, blank and synch SHALL be 0 by the cycle after entry.
REQ-027 A capture and an active-duty load in the same cycle are impossible by construction, because capture requires the buffer empty and load requires it full.

Reset
REQ-028 On rst_n low, the following SHALL take effect immediately and asynchronously:
- state IDLE, cnt 0;
- pending buffer empty and zero, active duties 0;
- hi, lo, blank, synch and running all 0; duty_rdy 1.
REQ-029 Reset asserted mid-period SHALL abort the period with no completion of the current pulse.

Structure
REQ-030 Package pwm_pkg SHALL hold the FSM state enum and the default values of W, DT and BLANK.
REQ-031 Sub-module pwm_chan SHALL implement one channel's compare logic, hi/lo flops and blank logic, instantiated NCH times by generate.
REQ-032 The counter, FSM and duty buffers SHALL reside in pwm_nch.

Verification (W=11, NCH=2, DT=64, BLANK=128)
REQ-033 Load duty0=1024, en=1 -> hi[0] rises the cycle after cnt=64 and falls after cnt=1024; lo[0] rises after cnt=1088 and falls after cnt=2047; blank[0] is high for cnt 65..191 and 1089..1215.
REQ-034 Set duty1=32 -> hi[1] stays 0 all period; lo[1] rises after cnt=96. Set duty1=2000 -> lo[1] stays 0; hi[1] is high from cnt 65 to 2000.
REQ-035 Apply a new duty with vld at cnt=500 -> duty_rdy drops; a second vld stalls until after cnt=2047; outputs change only from the next period.
REQ-036 Drop en at cnt=700 -> running stays 1 through cnt=2047; then the state is IDLE, cnt=0 and all outputs are 0. Re-raising en at cnt=900 resumes RUN with no gap.
REQ-037 Assert rst_n low at cnt=300 -> hi, lo, blank and synch go 0 with no clock edge; after release the module is in IDLE with duty_rdy=1.
REQ-038 The bench SHALL check every cycle that hi[c] and lo[c] are not both high and that synch pulses once per 2048 cycles while running.
